// File: rtl/mvmu_sequencer.sv
// mvmu_sequencer: upstream control stage for one MVMU tile.
// Packs a byte-serial weight stream into 16-byte write beats, latches one activation
// vector, drives the tile opcode/address/data/pim_in ports, and hands the captured
// column-result vector downstream over a valid/ready handshake.
// Optional compute watchdog: define MVMU_SEQ_TIMEOUT_EN.
// All outputs are registered; their next values are decoded from the next state.

module mvmu_sequencer #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned M_RAM_DEPTH    = 1024,
    parameter int unsigned B_RAM_DEPTH    = 32,
    parameter int unsigned NUM_OF_COLUMNS = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                               clk,
    input  logic                               RSTn,
    input  logic                               start,
    input  logic                               cmd_load,
    input  logic                               w_valid,
    output logic                               w_ready,
    input  logic [DATA_WIDTH-1:0]              w_data,
    input  logic                               act_valid,
    output logic                               act_ready,
    input  logic [DATA_WIDTH*B_RAM_DEPTH-1:0]  act_data,
    output logic [3:0]                         mvmu_web,
    output logic [15:0]                        mvmu_addr,
    output logic [16*DATA_WIDTH-1:0]           mvmu_data,
    output logic [DATA_WIDTH*B_RAM_DEPTH-1:0]  mvmu_pim_in,
    input  logic                               pim_pro_o_flag,
    input  logic [DATA_WIDTH*B_RAM_DEPTH-1:0]  pim_pro_q,
    output logic                               res_valid,
    input  logic                               res_ready,
    output logic [DATA_WIDTH*B_RAM_DEPTH-1:0]  res_data,
    output logic                               busy,
    output logic                               err
);

    localparam int unsigned NumBeats = M_RAM_DEPTH / 16;
    localparam int unsigned BeatW    = $clog2(NumBeats + 1);
    localparam int unsigned VecW     = DATA_WIDTH * B_RAM_DEPTH;
    localparam int unsigned BufW     = 16 * DATA_WIDTH;

    localparam logic [3:0] WebClean   = 4'd0;
    localparam logic [3:0] WebWrite   = 4'd1;
    localparam logic [3:0] WebNop     = 4'd3;
    localparam logic [3:0] WebPimPro  = 4'd4;
    localparam logic [3:0] WebPimIdle = 4'd5;

    // Elaboration-time parameter sanity checks
    if (DATA_WIDTH != 8) begin : g_chk_width
        $error("mvmu_sequencer: DATA_WIDTH must be 8");
    end
    if ((M_RAM_DEPTH % 16) != 0 || M_RAM_DEPTH == 0 || M_RAM_DEPTH > 65536) begin : g_chk_depth
        $error("mvmu_sequencer: M_RAM_DEPTH must be a non-zero multiple of 16 within 16-bit addressing");
    end
    // The watchdog must outlast a normal PIM_Pro pass
    if (TIMEOUT_CYCLES <= NUM_OF_COLUMNS + 1) begin : g_chk_timeout
        $error("mvmu_sequencer: TIMEOUT_CYCLES must exceed NUM_OF_COLUMNS+1");
    end

    typedef enum logic [2:0] {
        StIdle,
        StClean,
        StLoad,
        StWrite,
        StAct,
        StCompute,
        StResult,
        StPimRst
    } state_e;

    state_e              state_q, state_d;
    logic [BeatW-1:0]    beat_q, beat_d;
    logic [3:0]          byte_q, byte_d;
    logic [BufW-1:0]     buf_q, buf_d;
    logic [15:0]         addr_q, addr_d;
    logic [VecW-1:0]     pim_in_q, pim_in_d;
    logic [VecW-1:0]     res_data_q, res_data_d;
    logic                loaded_q, loaded_d;
    logic                err_q, err_d;
    logic [3:0]          web_q, web_d;
    logic                w_ready_q, w_ready_d;
    logic                act_ready_q, act_ready_d;
    logic                res_valid_q, res_valid_d;
    logic                busy_q, busy_d;

`ifdef MVMU_SEQ_TIMEOUT_EN
    localparam int unsigned TmoW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                   $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [TmoW-1:0]     tmo_q, tmo_d;
`endif

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        byte_d     = byte_q;
        buf_d      = buf_q;
        addr_d     = addr_q;
        pim_in_d   = pim_in_q;
        res_data_d = res_data_q;
        loaded_d   = loaded_q;
        err_d      = 1'b0;
`ifdef MVMU_SEQ_TIMEOUT_EN
        // Counter only advances while computing; it restarts on every entry
        tmo_d      = '0;
`endif

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (cmd_load) begin
                        state_d = StClean;
                    end else if (loaded_q) begin
                        state_d = StAct;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StClean: begin
                loaded_d = 1'b0;
                beat_d   = '0;
                byte_d   = '0;
                buf_d    = '0;
                state_d  = StLoad;
            end
            StLoad: begin
                if (w_valid && w_ready_q) begin
                    buf_d[byte_q*DATA_WIDTH +: DATA_WIDTH] = w_data;
                    // Wraps back to 0 after the 16th byte of the beat
                    byte_d = byte_q + 4'd1;
                    if (byte_q == 4'd15) begin
                        addr_d  = 16'(beat_q) << 4;
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                beat_d = beat_q + BeatW'(1);
                if (beat_q == BeatW'(NumBeats - 1)) begin
                    loaded_d = 1'b1;
                    state_d  = StAct;
                end else begin
                    state_d = StLoad;
                end
            end
            StAct: begin
                if (act_valid) begin
                    pim_in_d = act_data;
                    state_d  = StCompute;
                end
            end
            StCompute: begin
`ifdef MVMU_SEQ_TIMEOUT_EN
                tmo_d = tmo_q + TmoW'(1);
`endif
                if (pim_pro_o_flag) begin
                    res_data_d = pim_pro_q;
                    state_d    = StResult;
                end
`ifdef MVMU_SEQ_TIMEOUT_EN
                else if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
                    err_d      = 1'b1;
                    res_data_d = '0;
                    state_d    = StPimRst;
                end
`endif
            end
            StResult: begin
                if (res_valid_q && res_ready) begin
                    state_d = StPimRst;
                end
            end
            StPimRst: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are registered, so decode them from the state being entered
        unique case (state_d)
            StClean:   web_d = WebClean;
            StWrite:   web_d = WebWrite;
            StCompute: web_d = WebPimPro;
            StPimRst:  web_d = WebPimIdle;
            default:   web_d = WebNop;
        endcase
        w_ready_d   = (state_d == StLoad);
        act_ready_d = (state_d == StAct);
        res_valid_d = (state_d == StResult);
        busy_d      = (state_d != StIdle);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!RSTn) begin
            state_q     <= StIdle;
            beat_q      <= '0;
            byte_q      <= '0;
            buf_q       <= '0;
            addr_q      <= '0;
            pim_in_q    <= '0;
            res_data_q  <= '0;
            loaded_q    <= 1'b0;
            err_q       <= 1'b0;
            web_q       <= WebNop;
            w_ready_q   <= 1'b0;
            act_ready_q <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef MVMU_SEQ_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            byte_q      <= byte_d;
            buf_q       <= buf_d;
            addr_q      <= addr_d;
            pim_in_q    <= pim_in_d;
            res_data_q  <= res_data_d;
            loaded_q    <= loaded_d;
            err_q       <= err_d;
            web_q       <= web_d;
            w_ready_q   <= w_ready_d;
            act_ready_q <= act_ready_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
`ifdef MVMU_SEQ_TIMEOUT_EN
            tmo_q       <= tmo_d;
`endif
        end
    end

    assign w_ready     = w_ready_q;
    assign act_ready   = act_ready_q;
    assign mvmu_web    = web_q;
    assign mvmu_addr   = addr_q;
    assign mvmu_data   = buf_q;
    assign mvmu_pim_in = pim_in_q;
    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign busy        = busy_q;
    assign err         = err_q;

endmodule

// File: tb/tb_mvmu_sequencer.sv
// tb_mvmu_sequencer: directed bench for mvmu_sequencer with a behavioural MVMU tile.
// Timeout scenario runs only when MVMU_SEQ_TIMEOUT_EN is defined.

`define CHK(tag, obs, exp) \
    begin \
        n_cmp++; \
        assert ((obs) === (exp)) else begin \
            n_bad++; \
            $error("FAIL %s: observed %0h expected %0h", tag, (obs), (exp)); \
        end \
    end

module tb_mvmu_sequencer;

    localparam int MD = 1024;
    localparam int NC = 32;
    localparam int TO = 255;

    logic         clk = 1'b0;
    logic         RSTn;
    logic         start, cmd_load;
    logic         w_valid, w_ready;
    logic [7:0]   w_data;
    logic         act_valid, act_ready;
    logic [255:0] act_data;
    logic [3:0]   mvmu_web;
    logic [15:0]  mvmu_addr;
    logic [127:0] mvmu_data;
    logic [255:0] mvmu_pim_in;
    logic         pim_pro_o_flag;
    logic [255:0] pim_pro_q;
    logic         res_valid, res_ready;
    logic [255:0] res_data;
    logic         busy, err;

    int n_cmp = 0;
    int n_bad = 0;

    // Per-operation monitor counters, updated only from tick()
    int n_web0, n_web1, n_web4, n_web5, n_resv, n_beat_bad, n_web_bad;
    logic [127:0] exp_beat;
    logic [255:0] exp_res;
    int guard, k;

    always #5 clk = ~clk;

    mvmu_sequencer dut (
        .clk            (clk),
        .RSTn           (RSTn),
        .start          (start),
        .cmd_load       (cmd_load),
        .w_valid        (w_valid),
        .w_ready        (w_ready),
        .w_data         (w_data),
        .act_valid      (act_valid),
        .act_ready      (act_ready),
        .act_data       (act_data),
        .mvmu_web       (mvmu_web),
        .mvmu_addr      (mvmu_addr),
        .mvmu_data      (mvmu_data),
        .mvmu_pim_in    (mvmu_pim_in),
        .pim_pro_o_flag (pim_pro_o_flag),
        .pim_pro_q      (pim_pro_q),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_data       (res_data),
        .busy           (busy),
        .err            (err)
    );

    // Behavioural tile: 32x32 row-major weights, flag after NC+1 PIM_Pro cycles
    logic [7:0] tmem [0:MD-1];
    int         t_cnt;
    logic       tie_flag_low;

    function automatic logic [255:0] mvm_result();
        logic [255:0] r;
        logic [7:0]   acc;
        r = '0;
        for (int c = 0; c < 32; c++) begin
            acc = 8'h00;
            for (int row = 0; row < 32; row++) begin
                acc = acc + 8'(tmem[row*32+c] * mvmu_pim_in[row*8 +: 8]);
            end
            r[c*8 +: 8] = acc;
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (!RSTn) begin
            t_cnt          <= 0;
            pim_pro_o_flag <= 1'b0;
            pim_pro_q      <= '0;
        end else begin
            case (mvmu_web)
                4'd0: for (int i = 0; i < MD; i++) tmem[i] <= 8'h00;
                4'd1: for (int b = 0; b < 16; b++) tmem[int'(mvmu_addr) + b] <= mvmu_data[b*8 +: 8];
                4'd4: begin
                    t_cnt <= t_cnt + 1;
                    if (t_cnt == NC && !tie_flag_low) begin
                        pim_pro_o_flag <= 1'b1;
                        pim_pro_q      <= mvm_result();
                    end
                end
                4'd5: begin
                    t_cnt          <= 0;
                    pim_pro_o_flag <= 1'b0;
                    pim_pro_q      <= '0;
                end
                default: ;
            endcase
        end
    end

    task automatic clr_mon();
        n_web0 = 0; n_web1 = 0; n_web4 = 0; n_web5 = 0;
        n_resv = 0; n_beat_bad = 0; n_web_bad = 0;
    endtask

    // Advance to the next falling edge and record what the DUT is presenting
    task automatic tick();
        @(negedge clk);
        if (mvmu_web == 4'd0) n_web0++;
        if (mvmu_web == 4'd1) begin
            if (mvmu_addr !== 16'(n_web1 * 16) || mvmu_data !== exp_beat) n_beat_bad++;
            n_web1++;
        end
        if (mvmu_web == 4'd4) n_web4++;
        if (mvmu_web == 4'd5) n_web5++;
        if (res_valid) n_resv++;
        if (!(mvmu_web inside {4'd0, 4'd1, 4'd3, 4'd4, 4'd5})) n_web_bad++;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        RSTn = 1'b0; start = 1'b0; cmd_load = 1'b0; w_valid = 1'b0; w_data = 8'h00;
        act_valid = 1'b0; act_data = '0; res_ready = 1'b0; tie_flag_low = 1'b0;
        exp_beat = '0; exp_res = '0;
        clr_mon();
        repeat (3) tick();

        // Reset state
        `CHK("rst_web", mvmu_web, 4'd3)
        `CHK("rst_busy", busy, 1'b0)
        `CHK("rst_w_ready", w_ready, 1'b0)
        `CHK("rst_res_valid", res_valid, 1'b0)
        `CHK("rst_err", err, 1'b0)
        RSTn = 1'b1;
        tick();

        // Illegal reuse with nothing loaded
        start = 1'b1; cmd_load = 1'b0;
        tick();
        start = 1'b0;
        `CHK("illegal_err", err, 1'b1)
        `CHK("illegal_busy", busy, 1'b0)
        tick();
        `CHK("illegal_err_pulse", err, 1'b0)
        `CHK("illegal_web", mvmu_web, 4'd3)

        // Full load of 0x01 weights, act 0x01, result held under backpressure
        clr_mon();
        exp_beat = {16{8'h01}};
        act_data = {32{8'h01}}; act_valid = 1'b1;
        w_valid = 1'b1; w_data = 8'h01; res_ready = 1'b0;
        start = 1'b1; cmd_load = 1'b1;
        tick();
        start = 1'b0; cmd_load = 1'b0;
        `CHK("clean_web", mvmu_web, 4'd0)
        `CHK("clean_busy", busy, 1'b1)
        guard = 0;
        while (mvmu_web != 4'd4 && guard < 3000) begin
            tick();
            guard++;
        end
        `CHK("load_latency", guard, 1090)
        `CHK("load_clean_count", n_web0, 1)
        `CHK("load_beats", n_web1, 64)
        `CHK("load_beat_content", n_beat_bad, 0)
        `CHK("act_latched", mvmu_pim_in, {32{8'h01}})
        act_data = {32{8'hFF}};
        w_valid = 1'b0;
        guard = 0;
        while (!res_valid && guard < 200) begin
            tick();
            guard++;
        end
        act_valid = 1'b0;
        `CHK("compute_wait", (guard < 200), 1'b1)
        `CHK("compute_cycles", n_web4, 34)
        `CHK("run1_result", res_data, {32{8'h20}})
        `CHK("run1_pim_in_hold", mvmu_pim_in, {32{8'h01}})
        `CHK("run1_result_web", mvmu_web, 4'd3)
        for (int i = 0; i < 10; i++) begin
            tick();
            `CHK("bp_valid", res_valid, 1'b1)
            `CHK("bp_data", res_data, {32{8'h20}})
        end
        `CHK("bp_valid_cycles", n_resv, 11)
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        `CHK("pimrst_web", mvmu_web, 4'd5)
        `CHK("pimrst_valid", res_valid, 1'b0)
        tick();
        `CHK("idle_web", mvmu_web, 4'd3)
        `CHK("idle_busy", busy, 1'b0)
        `CHK("run1_pimrst_count", n_web5, 1)
        `CHK("run1_web_legal", n_web_bad, 0)

        // Reuse loaded weights with act 0x02
        clr_mon();
        act_data = {32{8'h02}}; act_valid = 1'b1; res_ready = 1'b1;
        start = 1'b1; cmd_load = 1'b0;
        tick();
        start = 1'b0;
        `CHK("reuse_act_ready", act_ready, 1'b1)
        guard = 0;
        while (!res_valid && guard < 200) begin
            tick();
            guard++;
        end
        act_valid = 1'b0;
        `CHK("reuse_wait", (guard < 200), 1'b1)
        `CHK("reuse_result", res_data, {32{8'h40}})
        `CHK("reuse_pim_in", mvmu_pim_in, {32{8'h02}})
        tick();
        `CHK("reuse_pimrst_web", mvmu_web, 4'd5)
        tick();
        `CHK("reuse_no_clean", n_web0, 0)
        `CHK("reuse_no_write", n_web1, 0)
        `CHK("reuse_idle_busy", busy, 1'b0)

        // Byte-indexed weights with producer gaps; checks byte placement in beats
        clr_mon();
        for (int b = 0; b < 16; b++) exp_beat[b*8 +: 8] = 8'(b);
        for (int c = 0; c < 32; c++) exp_res[c*8 +: 8] = 8'((c % 8) * 32);
        act_data = {32{8'h01}}; act_valid = 1'b1; res_ready = 1'b1;
        start = 1'b1; cmd_load = 1'b1;
        tick();
        start = 1'b0; cmd_load = 1'b0;
        k = 0; guard = 0;
        while (mvmu_web != 4'd4 && guard < 4000) begin
            w_valid = ($urandom_range(3) != 0);
            w_data  = 8'(k % 16);
            if (w_valid && w_ready) k++;
            tick();
            guard++;
        end
        w_valid = 1'b0;
        `CHK("pat_load_wait", (guard < 4000), 1'b1)
        `CHK("pat_bytes", k, 1024)
        `CHK("pat_beats", n_web1, 64)
        `CHK("pat_beat_content", n_beat_bad, 0)
        guard = 0;
        while (!res_valid && guard < 200) begin
            tick();
            guard++;
        end
        act_valid = 1'b0;
        `CHK("pat_result", res_data, exp_res)
        tick();
        tick();
        `CHK("pat_idle_busy", busy, 1'b0)

        // Reset in the middle of a load beat
        clr_mon();
        w_valid = 1'b1; w_data = 8'hAA;
        start = 1'b1; cmd_load = 1'b1;
        tick();
        start = 1'b0; cmd_load = 1'b0;
        repeat (5) tick();
        `CHK("midload_w_ready", w_ready, 1'b1)
        RSTn = 1'b0;
        tick();
        `CHK("midrst_web", mvmu_web, 4'd3)
        `CHK("midrst_w_ready", w_ready, 1'b0)
        `CHK("midrst_busy", busy, 1'b0)
        `CHK("midrst_addr", mvmu_addr, 16'h0000)
        `CHK("midrst_data", mvmu_data, 128'h0)
        `CHK("midrst_pim_in", mvmu_pim_in, 256'h0)
        `CHK("midrst_res_data", res_data, 256'h0)
        `CHK("midrst_act_ready", act_ready, 1'b0)
        RSTn = 1'b1; w_valid = 1'b0;
        tick();
        start = 1'b1; cmd_load = 1'b0;
        tick();
        start = 1'b0;
        `CHK("rst_clears_loaded_err", err, 1'b1)
        `CHK("rst_clears_loaded_busy", busy, 1'b0)

`ifdef MVMU_SEQ_TIMEOUT_EN
        // Watchdog: tile never raises its flag
        exp_beat = {16{8'h01}};
        w_valid = 1'b1; w_data = 8'h01;
        act_data = {32{8'h03}}; act_valid = 1'b1; res_ready = 1'b1;
        tie_flag_low = 1'b1;
        start = 1'b1; cmd_load = 1'b1;
        tick();
        start = 1'b0; cmd_load = 1'b0;
        guard = 0;
        while (mvmu_web != 4'd4 && guard < 3000) begin
            tick();
            guard++;
        end
        w_valid = 1'b0;
        clr_mon();
        n_web4 = 1;
        guard = 0;
        while (mvmu_web != 4'd5 && guard < 1000) begin
            tick();
            guard++;
        end
        act_valid = 1'b0;
        `CHK("tmo_compute_cycles", n_web4, TO)
        `CHK("tmo_err", err, 1'b1)
        `CHK("tmo_res_cleared", res_data, 256'h0)
        tick();
        `CHK("tmo_err_pulse", err, 1'b0)
        `CHK("tmo_idle_web", mvmu_web, 4'd3)
        `CHK("tmo_idle_busy", busy, 1'b0)
        `CHK("tmo_pimrst_count", n_web5, 1)
        `CHK("tmo_no_result", n_resv, 0)
        tie_flag_low = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
